// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit memory between the instruction
// fetch port and the data (load/store) port. One requester is granted at a
// time, the command is held for LATENCY cycles, the write (if any) happens in
// the last cycle of that window, and a one-cycle ready pulse follows.
//
// Optional feature macro: ARB_RR_EN
//   defined   -> round-robin arbitration on conflict (loser of the previous
//                grant wins)
//   undefined -> fixed priority, data port wins on conflict
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [15:0]           if_data,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_ready,
    output logic [15:0]           d_rdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Count starts at LATENCY-1 so that count==0 marks the last BUSY cycle.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state;
    logic [3:0]            count;
    logic                  grant_d;   // 1 = data port owns the current access
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [15:0]           lat_wdata;
    logic                  pick_d;    // arbitration result for this IDLE cycle
    logic                  last_step; // final cycle of the access window

`ifdef ARB_RR_EN
    logic last_grant_d;

    // Round-robin: on conflict the port that did not win last time wins.
    assign pick_d = d_req && (!if_req || !last_grant_d);

    // Remember who got the most recent grant; resets to fetch so the first
    // conflict goes to the data port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_d <= 1'b0;
        end else if (state == S_IDLE && (if_req || d_req)) begin
            last_grant_d <= pick_d;
        end
    end
`else
    // Fixed priority: data port wins whenever it requests.
    assign pick_d = d_req;
`endif

    assign last_step = (state == S_BUSY) && (count == 4'd0);

    // Outputs decoded from registered state only; an asynchronous reset
    // therefore drops mem_en and mem_wr without waiting for a clock edge.
    assign mem_en    = (state == S_BUSY);
    assign mem_wr    = last_step && lat_wr;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != S_IDLE);

    // Sequencer: grant in IDLE, count down in BUSY, pulse ready in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= 4'd0;
            grant_d   <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_data   <= '0;
            d_rdata   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        grant_d   <= pick_d;
                        lat_addr  <= pick_d ? d_addr : if_addr;
                        lat_wr    <= pick_d && d_wr;
                        lat_wdata <= pick_d ? d_wdata : 16'h0000;
                        count     <= CNT_LOAD;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (count == 4'd0) begin
                        // Reads capture the memory word; stores leave the
                        // read-data registers untouched.
                        if (!lat_wr) begin
                            if (grant_d) d_rdata <= mem_rdata;
                            else         if_data <= mem_rdata;
                        end
                        if_ready <= !grant_d;
                        d_ready  <= grant_d;
                        state    <= S_DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, scoreboard-based bench for mem_arbiter.
// Main instance uses LATENCY=4 with a small behavioural memory; a second
// instance with LATENCY=1 checks back-to-back throughput.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int LAT = 4;

    typedef struct packed {
        logic        is_data;
        logic        is_wr;
        logic [15:0] data;   // expected read data (or unchanged d_rdata for stores)
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic          if_req, if_ready, d_req, d_wr, d_ready;
    logic          mem_en, mem_wr, busy;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [15:0]   if_data, d_wdata, d_rdata, mem_wdata, mem_rdata;

    // LATENCY=1 DUT signals
    logic          l1_if_req, l1_if_ready, l1_d_ready, l1_mem_en, l1_mem_wr, l1_busy;
    logic [AW-1:0] l1_if_addr, l1_mem_addr;
    logic [15:0]   l1_if_data, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ready(l1_if_ready), .if_data(l1_if_data),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_ready(l1_d_ready), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    // Word memory for the main DUT: combinational read, write on mem_wr.
    logic [15:0] mem [0:255];
    logic        mem_clear;
    assign mem_rdata = mem[mem_addr[8:1]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h08] <= 16'hA5C3;   // byte 0x0010
            mem[8'h10] <= 16'hBEEF;   // byte 0x0020
            mem[8'h18] <= 16'h5555;   // byte 0x0030
        end else if (mem_wr) begin
            mem[mem_addr[8:1]] <= mem_wdata;
        end
    end

    // Fixed pattern memory for the LATENCY=1 instance.
    assign l1_mem_rdata = 16'hC0DE ^ l1_mem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pop the oldest expected completion and compare it with the ready cycle.
    task automatic sb_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_ready"}, {30'd0, d_ready, if_ready}, e.is_data ? 32'd2 : 32'd1);
        if (e.is_data) check({tag, "_d_rdata"}, {16'd0, d_rdata}, {16'd0, e.data});
        else           check({tag, "_if_data"}, {16'd0, if_data}, {16'd0, e.data});
    endtask

    // One uncontested access started in the current IDLE cycle.
    task automatic run_access(input logic is_data, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] exp_data,
                              input string tag);
        if (is_data) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        sb.push_back(exp_t'{is_data: is_data, is_wr: wr, data: exp_data});
        repeat (LAT) tick();
        tick();
        sb_pop(tag);
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        tick();
    endtask

    initial begin
        logic [5:0] pat;
        int         seen;

        if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        l1_if_req = 0; l1_if_addr = '0;
        mem_clear = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        mem_clear = 1'b0;

        // Reset values
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_mem_en",   {31'd0, mem_en},   32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_ready",    {30'd0, d_ready, if_ready}, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch from 0x0010
        if_req = 1'b1; if_addr = 16'h0010;
        sb.push_back(exp_t'{is_data: 1'b0, is_wr: 1'b0, data: 16'hA5C3});
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check($sformatf("fetch_en_c%0d", c), {31'd0, mem_en}, 32'd1);
        end
        check("fetch_addr", {16'd0, mem_addr}, 32'h0010);
        tick();
        sb_pop("fetch");
        check("fetch_en_off", {31'd0, mem_en}, 32'd0);
        if_req = 1'b0;
        tick();
        check("fetch_idle", {31'd0, busy}, 32'd0);

        // Both ports request for three accesses (last grant so far: fetch)
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
`ifdef ARB_RR_EN
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b0, data: 16'hBEEF});
        sb.push_back(exp_t'{is_data: 1'b0, is_wr: 1'b0, data: 16'hA5C3});
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b0, data: 16'hBEEF});
`else
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b0, data: 16'hBEEF});
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b0, data: 16'hBEEF});
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b0, data: 16'hBEEF});
`endif
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            repeat (LAT) tick();
            tick();
            sb_pop($sformatf("conflict%0d", k));
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // Store 0x1234 to 0x0100: write strobe only in the last BUSY cycle
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b1, data: 16'hBEEF});
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check($sformatf("store_wr_c%0d", c), {31'd0, mem_wr}, {31'd0, (c == LAT)});
        end
        check("store_wdata", {16'd0, mem_wdata}, 32'h1234);
        tick();
        sb_pop("store");
        d_req = 1'b0; d_wr = 1'b0;
        check("store_mem", {16'd0, mem[8'h80]}, 32'h1234);
        tick();

        // Load back from 0x0100
        run_access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234, "load");

        // Fetch whose address changes and req drops during BUSY
        if_req = 1'b1; if_addr = 16'h0020;
        sb.push_back(exp_t'{is_data: 1'b0, is_wr: 1'b0, data: 16'hBEEF});
        tick();
        if_addr = 16'h0030; if_req = 1'b0;
        repeat (LAT - 1) tick();
        check("chg_fetch_addr", {16'd0, mem_addr}, 32'h0020);
        tick();
        sb_pop("chg_fetch");
        tick();

        // Store whose address/data/wr change and req drops during BUSY
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h7777;
        sb.push_back(exp_t'{is_data: 1'b1, is_wr: 1'b1, data: 16'h1234});
        tick();
        d_addr = 16'h0050; d_wdata = 16'h9999; d_wr = 1'b0; d_req = 1'b0;
        repeat (LAT - 1) tick();
        check("chg_store_wr",    {31'd0, mem_wr},    32'd1);
        check("chg_store_wdata", {16'd0, mem_wdata}, 32'h7777);
        check("chg_store_addr",  {16'd0, mem_addr},  32'h0040);
        tick();
        sb_pop("chg_store");
        check("chg_store_mem",   {16'd0, mem[8'h20]}, 32'h7777);
        check("chg_store_other", {16'd0, mem[8'h28]}, 32'h0000);
        tick();

        // Asynchronous reset during BUSY cycle 2 of a store
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0060; d_wdata = 16'hDEAD;
        tick();
        tick();
        check("abort_en_before", {31'd0, mem_en}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_en",      {31'd0, mem_en},    32'd0);
        check("abort_wr",      {31'd0, mem_wr},    32'd0);
        check("abort_busy",    {31'd0, busy},      32'd0);
        check("abort_if_data", {16'd0, if_data},   32'd0);
        check("abort_d_rdata", {16'd0, d_rdata},   32'd0);
        check("abort_wdata",   {16'd0, mem_wdata}, 32'd0);
        d_req = 1'b0; d_wr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        seen = 0;
        repeat (2 * LAT) begin
            tick();
            if (d_ready || if_ready || busy) seen++;
        end
        check("abort_no_ready", seen, 32'd0);
        check("abort_mem",      {16'd0, mem[8'h30]}, 32'h0000);
        check("sb_drained",     sb.size(), 32'd0);

        // LATENCY=1 back-to-back fetches with req held
        l1_if_req = 1'b1; l1_if_addr = 16'h0004;
        pat = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            pat[c-1] = l1_if_ready;
            if (c == 5) l1_if_req = 1'b0;
        end
        check("lat1_ready_pattern", {26'd0, pat}, 32'b010010);
        check("lat1_if_data", {16'd0, l1_if_data}, 32'hC0DA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
